sync_fifo_core: RTL and testbench
=================================

Name: sync_fifo_core

Overview:
Single-clock, parametrised FIFO built around a dual-port memory array, with internal pointers and status generation. It supersedes the bare memory-plus-external-pointer arrangement and adds the following:
- occupancy count
- almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- selectable standard or first-word-fall-through (FWFT) read mode

It sits between a producer and a consumer in the same clock domain, and serves as the building block for rate buffering.

Parameters:
DATASIZE, 8, data word width in bits
ADDRSIZE, 4, address width; DEPTH = 2**ADDRSIZE entries
AFULL_LEVEL, 14, walmost_full asserts when count >= AFULL_LEVEL (legal range 1..DEPTH)
AEMPTY_LEVEL, 2, ralmost_empty asserts when count <= AEMPTY_LEVEL (legal range 0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
wclk  input  1  sole clock, rising edge
wrst_n  input  1  synchronous active-low reset, sampled on wclk
wdata  input  DATASIZE  write data
winc  input  1  push request
wfull  output  1  FIFO full (count == DEPTH)
walmost_full  output  1  count >= AFULL_LEVEL
rinc  input  1  pop request
rdata  output  DATASIZE  read data
rempty  output  1  FIFO empty (count == 0)
ralmost_empty  output  1  count <= AEMPTY_LEVEL
count  output  ADDRSIZE+1  current occupancy, 0..DEPTH
err_clr  input  1  clears the sticky error flags
overflow  output  1  sticky: a push was attempted while full
underflow  output  1  sticky: a pop was attempted while empty

Behaviour:
- Reset: synchronous on wclk when wrst_n=0.
  - wptr, rptr, count, overflow, underflow and the registered rdata are all cleared to 0.
  - Outputs after reset: rempty=1, wfull=0, ralmost_empty=1, walmost_full=0.
  - Memory contents are not reset.
  - Reset takes priority over every other input in the same cycle, including mid-burst; in-flight data is discarded.
- Pointers: wptr and rptr are ADDRSIZE+1 bits wide.
  - The low ADDRSIZE bits address the memory.
  - The pointers wrap naturally modulo 2**(ADDRSIZE+1).
  - count = wptr - rptr (modulo arithmetic). count is held as a register and updated in step with the pointers.
- Push and pop acceptance:
  - push = winc && !wfull. A push writes mem[wptr] <= wdata, then wptr+1.
  - pop = rinc && !rempty. A pop advances rptr+1.
  - When full, a push is rejected even if a pop occurs in the same cycle; no pass-through.
  - When empty, a pop is rejected even if a push occurs in the same cycle; no pass-through.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
- Status flags are combinational decodes of the count register, so they reflect the state after the previous edge:
  - wfull = (count == DEPTH)
  - rempty = (count == 0)
  - walmost_full and ralmost_empty compare count against AFULL_LEVEL and AEMPTY_LEVEL as defined in Parameters.
- Read mode FWFT=0:
  - rdata is a register, loaded with mem[rptr] on the edge where the pop is accepted (1-cycle latency).
  - rdata holds its value otherwise.
- Read mode FWFT=1:
  - rdata = mem[rptr] combinationally; the head word is visible while rempty=0, and rinc acknowledges it.
  - The value on rdata while rempty=1 is don't-care.
  - A word written on edge N is visible on rdata after edge N when the FIFO was empty.
- Error flags:
  - overflow is set on any edge with winc && wfull.
  - underflow is set on any edge with rinc && rempty.
  - Both flags stay set until err_clr=1 or reset.
  - If err_clr and a new error event occur on the same edge, the flag stays set (set wins).
- Boundary cases:
  - With DEPTH-1 entries, a push alone sets wfull on the next edge.
  - With count=1, a pop alone sets rempty on the next edge.
  - Pointer wrap past 2*DEPTH-1 is transparent to count and the flags.

Decomposition:
- Shared package fifo_pkg holds:
  - localparam helper DEPTH(ADDRSIZE)
  - the pointer and count widths
  - the read-mode encoding constants FIFO_STD=0 and FIFO_FWFT=1
- One sub-module, fifo_dp_ram: DATASIZE x DEPTH array with one synchronous write port (wclk, we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- sync_fifo_core owns the pointers, count, flags, error logic and the FWFT/standard output stage.

Test Plan:
- Reset, then check idle outputs -> rempty=1, wfull=0, count=0, overflow=0, underflow=0, rdata=0.
- Push 16 words 0x00..0x0F with defaults, then pop all 16 (FWFT=0) -> rdata follows 0x00..0x0F one cycle after each pop. walmost_full rises at count=14, wfull at 16, rempty returns at 0.
- Fill to 16, then winc=1 for 1 cycle -> overflow=1, count stays 16, data unchanged. Then pulse err_clr -> overflow=0 on the next edge.
- Empty FIFO with winc=1 and rinc=1 on the same edge (wdata=0xA5) -> count=1, underflow=1. FWFT=1: rdata=0xA5 after the edge.
- Stream continuous push and pop for 40 cycles at count=8 -> count stays 8 and the pointers wrap twice with the data order intact.
- Hold wrst_n=0 for 1 cycle at count=10 -> on the next edge count=0, rempty=1, and the flags are cleared.

Source files
------------

// File: rtl/sync_fifo_core_pkg.sv
// Shared sizing helpers and read-mode encodings for the synchronous FIFO.
package fifo_pkg;

   localparam int FIFO_STD  = 0;
   localparam int FIFO_FWFT = 1;

   function automatic int fifo_depth(input int addrsize);
      return 1 << addrsize;
   endfunction

   // One extra bit lets count and the pointers represent a completely full FIFO.
   function automatic int ptr_width(input int addrsize);
      return addrsize + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_core_if.sv
// Producer/consumer-side bundle of the synchronous FIFO, with status and error outputs.
interface sync_fifo_core_if #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
);
   logic [DATASIZE-1:0] wdata;
   logic                winc;
   logic                wfull;
   logic                walmost_full;
   logic                rinc;
   logic [DATASIZE-1:0] rdata;
   logic                rempty;
   logic                ralmost_empty;
   logic [ADDRSIZE:0]   count;
   logic                err_clr;
   logic                overflow;
   logic                underflow;

   modport master (
      output wdata, winc, rinc, err_clr,
      input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
   );

   modport slave (
      input  wdata, winc, rinc, err_clr,
      output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_core_dp_ram.sv
// Storage array: one synchronous write port and one asynchronous read port.
module fifo_dp_ram #(
   parameter int DATASIZE = 8,
   parameter int ADDRSIZE = 4
) (
   input  logic                wclk,
   input  logic                we,
   input  logic [ADDRSIZE-1:0] waddr,
   input  logic [DATASIZE-1:0] wdata,
   input  logic [ADDRSIZE-1:0] raddr,
   output logic [DATASIZE-1:0] rdata
);
   logic [DATASIZE-1:0] mem [2**ADDRSIZE];

   // NOTE: the array has no reset; the pointers alone decide which entries are valid,
   // and leaving it out keeps the array mappable onto plain RAM.
   always_ff @(posedge wclk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO: pointers, registered occupancy, threshold flags, sticky errors,
// and a standard (registered) or first-word-fall-through read port.
module sync_fifo_core
   import fifo_pkg::*;
#(
   parameter int DATASIZE     = 8,
   parameter int ADDRSIZE     = 4,
   parameter int AFULL_LEVEL  = 14,
   parameter int AEMPTY_LEVEL = 2,
   parameter int FWFT         = FIFO_STD
) (
   input  logic                wclk,
   input  logic                wrst_n,
   sync_fifo_core_if.slave     bus
);
   localparam int PW = ptr_width(ADDRSIZE);

   typedef logic [PW-1:0] ptr_t;

   localparam ptr_t DEPTH_C  = ptr_t'(fifo_depth(ADDRSIZE));
   localparam ptr_t AFULL_C  = ptr_t'(AFULL_LEVEL);
   localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_LEVEL);
   localparam ptr_t ONE_C    = ptr_t'(1);

   ptr_t                wptr_q, wptr_d;
   ptr_t                rptr_q, rptr_d;
   ptr_t                count_q, count_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic [DATASIZE-1:0] rdata_q, rdata_d;
   logic [DATASIZE-1:0] ram_rdata;
   logic                full, empty, push, pop;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);
   // No pass-through: acceptance looks only at the state left by the previous edge.
   assign push  = bus.winc && !full;
   assign pop   = bus.rinc && !empty;

   // NOTE: every variable gets its hold value first so no path can infer a latch.
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      rdata_d     = rdata_q;
      overflow_d  = (overflow_q  && !bus.err_clr) || (bus.winc && full);
      underflow_d = (underflow_q && !bus.err_clr) || (bus.rinc && empty);

      if (push) begin
         wptr_d = wptr_q + ONE_C;
      end
      if (pop) begin
         rptr_d  = rptr_q + ONE_C;
         rdata_d = ram_rdata;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + ONE_C;
         2'b01:   count_d = count_q - ONE_C;
         default: count_d = count_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rdata_q     <= rdata_d;
      end
   end

   fifo_dp_ram #(
      .DATASIZE (DATASIZE),
      .ADDRSIZE (ADDRSIZE)
   ) u_ram (
      .wclk  (wclk),
      .we    (push),
      .waddr (wptr_q[ADDRSIZE-1:0]),
      .wdata (bus.wdata),
      .raddr (rptr_q[ADDRSIZE-1:0]),
      .rdata (ram_rdata)
   );

   assign bus.rdata         = (FWFT == FIFO_FWFT) ? ram_rdata : rdata_q;
   assign bus.count         = count_q;
   assign bus.wfull         = full;
   assign bus.rempty        = empty;
   assign bus.walmost_full  = (count_q >= AFULL_C);
   assign bus.ralmost_empty = (count_q <= AEMPTY_C);
   assign bus.overflow      = overflow_q;
   assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo_core.sv
// Scoreboard bench: a standard-mode and an FWFT-mode FIFO driven with identical stimulus.
module tb_sync_fifo_core;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       winc = 1'b0;
   logic       rinc = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] wdata = 8'h00;

   int         n_tests = 0;
   int         n_fail  = 0;

   logic [7:0] sb[$];
   logic [7:0] exp_std = 8'h00;
   logic       m_ovf = 1'b0;
   logic       m_udf = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_core_if #(.DATASIZE(8), .ADDRSIZE(4)) f_std ();
   sync_fifo_core_if #(.DATASIZE(8), .ADDRSIZE(4)) f_fw ();

   assign f_std.winc = winc;  assign f_fw.winc = winc;
   assign f_std.rinc = rinc;  assign f_fw.rinc = rinc;
   assign f_std.wdata = wdata; assign f_fw.wdata = wdata;
   assign f_std.err_clr = err_clr; assign f_fw.err_clr = err_clr;

   sync_fifo_core #(
      .DATASIZE(8), .ADDRSIZE(4), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2), .FWFT(0)
   ) u_std (
      .wclk   (clk),
      .wrst_n (rst_n),
      .bus    (f_std.slave)
   );

   sync_fifo_core #(
      .DATASIZE(8), .ADDRSIZE(4), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2), .FWFT(1)
   ) u_fw (
      .wclk   (clk),
      .wrst_n (rst_n),
      .bus    (f_fw.slave)
   );

   // One clock of stimulus; the model decides acceptance from its own occupancy.
   task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic clr);
      logic full, empty, push, pop;
      full  = (sb.size() == DEPTH);
      empty = (sb.size() == 0);
      push  = w && !full;
      pop   = r && !empty;
      winc = w; wdata = d; rinc = r; err_clr = clr;
      @(posedge clk);
      #1;
      winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
      m_ovf = (m_ovf && !clr) || (w && full);
      m_udf = (m_udf && !clr) || (r && empty);
      if (pop)  exp_std = sb.pop_front();
      if (push) sb.push_back(d);
   endtask

   task automatic apply_reset(input logic busy);
      rst_n = 1'b0; winc = busy; rinc = busy; wdata = 8'h77;
      @(posedge clk);
      #1;
      rst_n = 1'b1; winc = 1'b0; rinc = 1'b0;
      sb.delete();
      exp_std = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset(1'b0);
      apply_reset(1'b0);
      n_tests++;
      if (f_std.rempty !== 1'b1 || f_std.wfull !== 1'b0 || f_std.count !== 5'd0 ||
          f_std.ralmost_empty !== 1'b1 || f_std.walmost_full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_status: empty=%b full=%b count=%0d ae=%b af=%b, need 1 0 0 1 0",
                  f_std.rempty, f_std.wfull, f_std.count, f_std.ralmost_empty, f_std.walmost_full);
      end
      n_tests++;
      if (f_std.overflow !== 1'b0 || f_std.underflow !== 1'b0 || f_std.rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_regs: ovf=%b udf=%b rdata=%h, need 0 0 00",
                  f_std.overflow, f_std.underflow, f_std.rdata);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0);
         n_tests++;
         if (f_std.count !== 5'(i + 1) || f_std.walmost_full !== (i + 1 >= 14) ||
             f_std.wfull !== (i + 1 == 16) || f_std.rempty !== 1'b0 ||
             f_std.ralmost_empty !== (i + 1 <= 2)) begin
            n_fail++;
            $display("FAIL fill_status[%0d]: count=%0d af=%b full=%b empty=%b ae=%b",
                     i, f_std.count, f_std.walmost_full, f_std.wfull, f_std.rempty, f_std.ralmost_empty);
         end
         n_tests++;
         if (f_fw.rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL fill_fwft_head[%0d]: got %h need 00", i, f_fw.rdata);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         n_tests++;
         if (f_std.rdata !== 8'(i) || exp_std !== 8'(i)) begin
            n_fail++;
            $display("FAIL drain_data[%0d]: got %h need %h", i, f_std.rdata, 8'(i));
         end
         n_tests++;
         if (f_std.count !== 5'(15 - i) || f_std.rempty !== (i == 15) || f_std.wfull !== 1'b0 ||
             f_std.ralmost_empty !== (15 - i <= 2) || f_std.walmost_full !== (15 - i >= 14)) begin
            n_fail++;
            $display("FAIL drain_status[%0d]: count=%0d empty=%b full=%b ae=%b af=%b",
                     i, f_std.count, f_std.rempty, f_std.wfull, f_std.ralmost_empty, f_std.walmost_full);
         end
         if (i < DEPTH - 1) begin
            n_tests++;
            if (f_fw.rdata !== 8'(i + 1)) begin
               n_fail++;
               $display("FAIL drain_fwft_head[%0d]: got %h need %h", i, f_fw.rdata, 8'(i + 1));
            end
         end
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      n_tests++;
      if (f_std.overflow !== 1'b1 || f_std.count !== 5'd16 || f_std.wfull !== 1'b1 || m_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set: ovf=%b count=%0d full=%b, need 1 16 1",
                  f_std.overflow, f_std.count, f_std.wfull);
      end
      drive(1'b1, 8'hEE, 1'b0, 1'b1);
      n_tests++;
      if (f_std.overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set_wins: got %b need 1", f_std.overflow);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      n_tests++;
      if (f_std.overflow !== 1'b0 || f_fw.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: std=%b fwft=%b need 0", f_std.overflow, f_fw.overflow);
      end
      while (sb.size() != 0) begin
         logic [7:0] head;
         head = sb[0];
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         n_tests++;
         if (f_std.rdata !== head) begin
            n_fail++;
            $display("FAIL ovf_data_intact: got %h need %h", f_std.rdata, head);
         end
      end
   endtask

   task automatic test_simul_empty();
      logic [7:0] held;
      held = exp_std;
      drive(1'b1, 8'hA5, 1'b1, 1'b0);
      n_tests++;
      if (f_std.count !== 5'd1 || f_std.underflow !== m_udf || m_udf !== 1'b1 || f_std.rempty !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_empty: count=%0d udf=%b empty=%b, need 1 1 0",
                  f_std.count, f_std.underflow, f_std.rempty);
      end
      n_tests++;
      if (f_fw.rdata !== 8'hA5 || f_std.rdata !== held) begin
         n_fail++;
         $display("FAIL simul_rdata: fwft=%h need a5, std=%h need %h", f_fw.rdata, f_std.rdata, held);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
         n_tests++;
         if (f_std.rdata !== exp_std || f_std.count !== 5'd8 || f_fw.count !== 5'd8) begin
            n_fail++;
            $display("FAIL stream[%0d]: rdata=%h need %h count=%0d need 8",
                     i, f_std.rdata, exp_std, f_std.count);
         end
         n_tests++;
         if (f_fw.rdata !== sb[0]) begin
            n_fail++;
            $display("FAIL stream_fwft[%0d]: got %h need %h", i, f_fw.rdata, sb[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 8'hC0, 1'b0, 1'b0);
      drive(1'b1, 8'hC1, 1'b0, 1'b0);
      n_tests++;
      if (f_std.count !== 5'd10 || f_std.underflow !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: count=%0d udf=%b need 10 1", f_std.count, f_std.underflow);
      end
      apply_reset(1'b1);
      n_tests++;
      if (f_std.count !== 5'd0 || f_std.rempty !== 1'b1 || f_std.underflow !== 1'b0 ||
          f_std.overflow !== 1'b0 || f_std.rdata !== 8'h00 || f_fw.count !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_mid: count=%0d empty=%b udf=%b ovf=%b rdata=%h",
                  f_std.count, f_std.rempty, f_std.underflow, f_std.overflow, f_std.rdata);
      end
      drive(1'b1, 8'h3C, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      n_tests++;
      if (f_std.rdata !== 8'h3C || f_std.rempty !== 1'b1) begin
         n_fail++;
         $display("FAIL post_reset_data: got %h need 3c", f_std.rdata);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_simul_empty();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
